// File: rtl/vx_mem_perf_tracker_pkg.sv
// Shared defaults and sizing helpers for the memory-side performance tracker.
package vx_mem_perf_tracker_pkg;

   localparam int unsigned PERF_CTR_BITS_DEF = 44;
   localparam int unsigned LSU_LANES_DEF     = 4;
   localparam int unsigned PEND_BITS_DEF     = 8;

   // Bits needed to hold a count of 0..n.
   function automatic int unsigned count_bits(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   typedef struct packed {
      logic ifetch;
      logic loads;
   } pend_clamp_t;

endpackage

// File: rtl/vx_perf_pending_ctr.sv
// Saturating up/down outstanding-request counter; clamp flags an update that hit 0 or max.
module vx_perf_pending_ctr
   import vx_mem_perf_tracker_pkg::*;
#(
   parameter int unsigned CNT_BITS = 8,
   parameter int unsigned INC_BITS = 1,
   parameter int unsigned DEC_BITS = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [INC_BITS-1:0] inc,
   input  logic [DEC_BITS-1:0] dec,
   output logic [CNT_BITS-1:0] count,
   output logic                clamp
);

   // Two guard bits so count + inc can never overflow the working width.
   localparam int unsigned W = max_u(CNT_BITS, max_u(INC_BITS, DEC_BITS)) + 2;
   localparam logic [W-1:0] MAX_VAL = {{(W-CNT_BITS){1'b0}}, {CNT_BITS{1'b1}}};

   logic [W-1:0]        up;
   logic [W-1:0]        diff;
   logic [CNT_BITS-1:0] count_nxt;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      up        = W'(count) + W'(inc);
      diff      = up - W'(dec);
      count_nxt = CNT_BITS'(diff);
      clamp     = 1'b0;
      if (up < W'(dec)) begin
         count_nxt = '0;
         clamp     = 1'b1;
      end else if (diff > MAX_VAL) begin
         count_nxt = MAX_VAL[CNT_BITS-1:0];
         clamp     = 1'b1;
      end
   end

   // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count <= '0;
      else          count <= count_nxt;
   end

endmodule

// File: rtl/vx_mem_perf_tracker.sv
// Counts I/D-cache requests and accumulates latency as the per-cycle sum of outstanding requests.
module vx_mem_perf_tracker
   import vx_mem_perf_tracker_pkg::*;
#(
   parameter int unsigned PERF_CTR_BITS = PERF_CTR_BITS_DEF,
   parameter int unsigned NUM_REQS      = LSU_LANES_DEF,
   parameter int unsigned PEND_BITS     = PEND_BITS_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     perf_enable,
   input  logic                     perf_clear,
   input  logic                     icache_req_fire,
   input  logic                     icache_rsp_fire,
   input  logic [NUM_REQS-1:0]      dcache_req_fire,
   input  logic [NUM_REQS-1:0]      dcache_req_rw,
   input  logic [NUM_REQS-1:0]      dcache_rsp_fire,
   output logic [PERF_CTR_BITS-1:0] ifetches,
   output logic [PERF_CTR_BITS-1:0] loads,
   output logic [PERF_CTR_BITS-1:0] stores,
   output logic [PERF_CTR_BITS-1:0] ifetch_latency,
   output logic [PERF_CTR_BITS-1:0] load_latency,
   output logic [PEND_BITS-1:0]     pending_ifetch,
   output logic [PEND_BITS-1:0]     pending_loads,
   output logic                     pend_err
);

   localparam int unsigned CW = count_bits(NUM_REQS);

   logic [CW-1:0] n_ld;
   logic [CW-1:0] n_st;
   logic [CW-1:0] n_lrsp;
   pend_clamp_t   clamp;

   always_comb begin
      n_ld   = '0;
      n_st   = '0;
      n_lrsp = '0;
      for (int i = 0; i < int'(NUM_REQS); i++) begin
         n_ld   = n_ld   + CW'(dcache_req_fire[i] & ~dcache_req_rw[i]);
         n_st   = n_st   + CW'(dcache_req_fire[i] &  dcache_req_rw[i]);
         n_lrsp = n_lrsp + CW'(dcache_rsp_fire[i]);
      end
   end

   vx_perf_pending_ctr #(
      .CNT_BITS (PEND_BITS),
      .INC_BITS (1),
      .DEC_BITS (1)
   ) u_pend_ifetch (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (icache_req_fire),
      .dec     (icache_rsp_fire),
      .count   (pending_ifetch),
      .clamp   (clamp.ifetch)
   );

   vx_perf_pending_ctr #(
      .CNT_BITS (PEND_BITS),
      .INC_BITS (CW),
      .DEC_BITS (CW)
   ) u_pend_loads (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (n_ld),
      .dec     (n_lrsp),
      .count   (pending_loads),
      .clamp   (clamp.loads)
   );

   // Latency adds the pre-update pending values, so a request answered L cycles later adds exactly L.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifetches       <= '0;
         loads          <= '0;
         stores         <= '0;
         ifetch_latency <= '0;
         load_latency   <= '0;
         pend_err       <= 1'b0;
      end else begin
         if (perf_clear) begin
            ifetches       <= '0;
            loads          <= '0;
            stores         <= '0;
            ifetch_latency <= '0;
            load_latency   <= '0;
         end else if (perf_enable) begin
            ifetches       <= ifetches + PERF_CTR_BITS'(icache_req_fire);
            loads          <= loads + PERF_CTR_BITS'(n_ld);
            stores         <= stores + PERF_CTR_BITS'(n_st);
            ifetch_latency <= ifetch_latency + PERF_CTR_BITS'(pending_ifetch);
            load_latency   <= load_latency + PERF_CTR_BITS'(pending_loads);
         end

         if (perf_clear)  pend_err <= 1'b0;
         else if (|clamp) pend_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vx_mem_perf_tracker.sv
// Scoreboard bench: stimulus queues expected outputs tagged by cycle, a negedge monitor compares them.
module tb_vx_mem_perf_tracker;

   logic        clk;
   logic        reset_n;
   logic        perf_enable;
   logic        perf_clear;
   logic        icache_req_fire;
   logic        icache_rsp_fire;
   logic [3:0]  dcache_req_fire;
   logic [3:0]  dcache_req_rw;
   logic [3:0]  dcache_rsp_fire;
   logic [43:0] ifetches, loads, stores, ifetch_latency, load_latency;
   logic [7:0]  pending_ifetch, pending_loads;
   logic        pend_err;

   logic        s_icache_req_fire;
   logic        s_icache_rsp_fire;
   logic [0:0]  s_dcache_req_fire;
   logic [0:0]  s_dcache_req_rw;
   logic [0:0]  s_dcache_rsp_fire;
   logic [3:0]  s_ifetches, s_loads, s_stores, s_ifetch_latency, s_load_latency;
   logic [1:0]  s_pending_ifetch, s_pending_loads;
   logic        s_pend_err;

   vx_mem_perf_tracker dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .perf_enable     (perf_enable),
      .perf_clear      (perf_clear),
      .icache_req_fire (icache_req_fire),
      .icache_rsp_fire (icache_rsp_fire),
      .dcache_req_fire (dcache_req_fire),
      .dcache_req_rw   (dcache_req_rw),
      .dcache_rsp_fire (dcache_rsp_fire),
      .ifetches        (ifetches),
      .loads           (loads),
      .stores          (stores),
      .ifetch_latency  (ifetch_latency),
      .load_latency    (load_latency),
      .pending_ifetch  (pending_ifetch),
      .pending_loads   (pending_loads),
      .pend_err        (pend_err)
   );

   vx_mem_perf_tracker #(
      .PERF_CTR_BITS (4),
      .NUM_REQS      (1),
      .PEND_BITS     (2)
   ) dut_small (
      .clk             (clk),
      .reset_n         (reset_n),
      .perf_enable     (perf_enable),
      .perf_clear      (perf_clear),
      .icache_req_fire (s_icache_req_fire),
      .icache_rsp_fire (s_icache_rsp_fire),
      .dcache_req_fire (s_dcache_req_fire),
      .dcache_req_rw   (s_dcache_req_rw),
      .dcache_rsp_fire (s_dcache_rsp_fire),
      .ifetches        (s_ifetches),
      .loads           (s_loads),
      .stores          (s_stores),
      .ifetch_latency  (s_ifetch_latency),
      .load_latency    (s_load_latency),
      .pending_ifetch  (s_pending_ifetch),
      .pending_loads   (s_pending_loads),
      .pend_err        (s_pend_err)
   );

   typedef enum int {
      S_IFETCHES, S_LOADS, S_STORES, S_IFLAT, S_LDLAT, S_PEND_I, S_PEND_L, S_PERR,
      SM_IFETCHES, SM_PEND_I, SM_PERR
   } sel_e;

   typedef struct {
      int          cyc;
      sel_e        sel;
      logic [63:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb[$];
   int       cyc = 0;
   int       checks = 0;
   int       failures = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] actual_of(input sel_e s);
      case (s)
         S_IFETCHES:  return 64'(ifetches);
         S_LOADS:     return 64'(loads);
         S_STORES:    return 64'(stores);
         S_IFLAT:     return 64'(ifetch_latency);
         S_LDLAT:     return 64'(load_latency);
         S_PEND_I:    return 64'(pending_ifetch);
         S_PEND_L:    return 64'(pending_loads);
         S_PERR:      return 64'(pend_err);
         SM_IFETCHES: return 64'(s_ifetches);
         SM_PEND_I:   return 64'(s_pending_ifetch);
         SM_PERR:     return 64'(s_pend_err);
         default:     return 64'hDEAD;
      endcase
   endfunction

   task automatic exp_at(input int d, input sel_e s, input logic [63:0] v, input string n);
      sb_item_t it;
      it.cyc  = cyc + d;
      it.sel  = s;
      it.exp  = v;
      it.name = n;
      sb.push_back(it);
   endtask

   // Monitor: compare every expectation due this cycle, away from the active edge.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].name, actual_of(sb[i].sel), sb[i].exp);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d never compared", sb[i].name, sb[i].cyc);
            sb.delete(i);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ifetches"}, 64'(ifetches), 0);
      check({tag, "_loads"}, 64'(loads), 0);
      check({tag, "_stores"}, 64'(stores), 0);
      check({tag, "_iflat"}, 64'(ifetch_latency), 0);
      check({tag, "_ldlat"}, 64'(load_latency), 0);
      check({tag, "_pend_i"}, 64'(pending_ifetch), 0);
      check({tag, "_pend_l"}, 64'(pending_loads), 0);
      check({tag, "_pend_err"}, 64'(pend_err), 0);
      check({tag, "_s_ifetches"}, 64'(s_ifetches), 0);
      check({tag, "_s_pend_i"}, 64'(s_pending_ifetch), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      perf_enable = 1'b1;
      perf_clear = 1'b0;
      icache_req_fire = 1'b0;
      icache_rsp_fire = 1'b0;
      dcache_req_fire = '0;
      dcache_req_rw = '0;
      dcache_rsp_fire = '0;
      s_icache_req_fire = 1'b0;
      s_icache_rsp_fire = 1'b0;
      s_dcache_req_fire = '0;
      s_dcache_req_rw = '0;
      s_dcache_rsp_fire = '0;

      #2;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      step(2);

      // I-cache request, response 4 cycles later.
      icache_req_fire = 1'b1;
      exp_at(1, S_IFETCHES, 1, "if_count");
      exp_at(1, S_PEND_I, 1, "if_pend_up");
      exp_at(1, S_IFLAT, 0, "if_lat_first");
      exp_at(2, S_IFLAT, 1, "if_lat_mid");
      exp_at(5, S_IFLAT, 4, "if_lat_final");
      exp_at(5, S_PEND_I, 0, "if_pend_back");
      exp_at(5, S_IFETCHES, 1, "if_count_hold");
      step;
      icache_req_fire = 1'b0;
      step(3);
      icache_rsp_fire = 1'b1;
      step;
      icache_rsp_fire = 1'b0;
      step(2);

      // Two loads (lanes 1,3) and two stores (lanes 0,2); load responses 3 cycles later.
      dcache_req_fire = 4'b1111;
      dcache_req_rw = 4'b0101;
      exp_at(1, S_LOADS, 2, "dc_loads");
      exp_at(1, S_STORES, 2, "dc_stores");
      exp_at(1, S_PEND_L, 2, "dc_pend_up");
      exp_at(4, S_LDLAT, 6, "dc_lat");
      exp_at(4, S_PEND_L, 0, "dc_pend_back");
      exp_at(5, S_LDLAT, 6, "dc_lat_hold");
      step;
      dcache_req_fire = '0;
      dcache_req_rw = '0;
      step(2);
      dcache_rsp_fire = 4'b1010;
      step;
      dcache_rsp_fire = '0;
      step(2);

      // Latency freezes while disabled, pending keeps tracking, then accumulation resumes.
      dcache_req_fire = 4'b0001;
      exp_at(1, S_LOADS, 3, "en_loads");
      exp_at(1, S_PEND_L, 1, "en_pend1");
      exp_at(1, S_LDLAT, 6, "en_lat0");
      exp_at(2, S_PEND_L, 2, "dis_pend_tracks");
      exp_at(2, S_LOADS, 3, "dis_loads_hold");
      exp_at(6, S_LDLAT, 6, "dis_lat_hold");
      exp_at(6, S_PEND_L, 2, "dis_pend_hold");
      exp_at(7, S_LDLAT, 8, "reen_lat");
      exp_at(8, S_LDLAT, 10, "reen_lat2");
      exp_at(8, S_PEND_L, 0, "reen_pend0");
      exp_at(8, S_LOADS, 3, "reen_loads");
      step;
      perf_enable = 1'b0;
      dcache_req_fire = 4'b0001;
      step;
      dcache_req_fire = '0;
      step(4);
      perf_enable = 1'b1;
      step;
      dcache_rsp_fire = 4'b0011;
      step;
      dcache_rsp_fire = '0;
      step(2);

      // Response with nothing outstanding: clamp at 0, sticky error.
      icache_rsp_fire = 1'b1;
      exp_at(1, S_PEND_I, 0, "uf_pend");
      exp_at(1, S_PERR, 1, "uf_err");
      exp_at(3, S_PERR, 1, "uf_err_sticky");
      exp_at(3, S_IFLAT, 4, "uf_lat_hold");
      step;
      icache_rsp_fire = 1'b0;
      step(3);

      // Clear while two ifetches outstanding and a third issuing.
      icache_req_fire = 1'b1;
      exp_at(2, S_PEND_I, 2, "pc_pend2");
      exp_at(2, S_IFETCHES, 3, "pc_count3");
      exp_at(2, S_IFLAT, 5, "pc_lat5");
      exp_at(2, S_PERR, 1, "pc_err_pre");
      step(2);
      perf_clear = 1'b1;
      exp_at(1, S_IFETCHES, 0, "clr_ifetches");
      exp_at(1, S_IFLAT, 0, "clr_iflat");
      exp_at(1, S_LOADS, 0, "clr_loads");
      exp_at(1, S_STORES, 0, "clr_stores");
      exp_at(1, S_LDLAT, 0, "clr_ldlat");
      exp_at(1, S_PEND_I, 3, "clr_pend_kept");
      exp_at(1, S_PERR, 0, "clr_err");
      exp_at(2, S_IFLAT, 3, "clr_lat_resume");
      exp_at(2, S_IFETCHES, 0, "clr_count_hold");
      exp_at(2, S_PEND_I, 3, "clr_pend_hold");
      step;
      perf_clear = 1'b0;
      icache_req_fire = 1'b0;
      step(3);

      // Asynchronous reset between edges while traffic is in flight.
      icache_req_fire = 1'b1;
      dcache_req_fire = 4'b0011;
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      icache_req_fire = 1'b0;
      dcache_req_fire = '0;
      @(negedge clk);
      reset_n = 1'b1;
      step;
      icache_rsp_fire = 1'b1;
      dcache_rsp_fire = 4'b0001;
      exp_at(1, S_PEND_I, 0, "post_rst_pend_i");
      exp_at(1, S_PEND_L, 0, "post_rst_pend_l");
      exp_at(1, S_PERR, 1, "post_rst_err");
      exp_at(1, S_IFETCHES, 0, "post_rst_ifetches");
      exp_at(1, S_LDLAT, 0, "post_rst_ldlat");
      step;
      icache_rsp_fire = 1'b0;
      dcache_rsp_fire = '0;
      step(2);

      // Narrow build: pending saturates at 3, 4-bit ifetches wraps after 16.
      s_icache_req_fire = 1'b1;
      exp_at(3, SM_PEND_I, 3, "sm_pend3");
      exp_at(3, SM_PERR, 0, "sm_err_clear");
      exp_at(4, SM_PEND_I, 3, "sm_pend_sat");
      exp_at(4, SM_PERR, 1, "sm_err_set");
      exp_at(4, SM_IFETCHES, 4, "sm_count4");
      exp_at(15, SM_IFETCHES, 15, "sm_count_max");
      exp_at(16, SM_IFETCHES, 0, "sm_wrap");
      exp_at(16, SM_PERR, 1, "sm_err_sticky");
      step(16);
      s_icache_req_fire = 1'b0;
      step(3);

      while (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s: expectation left unchecked", sb[0].name);
         void'(sb.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vx_mem_perf_tracker.md
# vx_mem_perf_tracker

Memory-side performance tracker that produces the `ifetches`, `loads`, `stores`, `ifetch_latency` and `load_latency` counters consumed by the pipeline performance interface's slave side. It sits beside the fetch unit and LSU. It samples request/response handshake fires on the I-cache and D-cache ports, counts requests, and accumulates latency as the per-cycle sum of outstanding requests. Software computes average latency as `*_latency / count`.

## Interface
Parameters:
- `PERF_CTR_BITS`, default 44: width of every event/latency counter.
- `NUM_REQS`, default 4: D-cache request/response lanes.
- `PEND_BITS`, default 8: width of the outstanding-request counters.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `perf_enable` in 1: event and latency counters advance only while 1.
- `perf_clear` in 1: synchronous clear of event/latency counters and `pend_err`.
- `icache_req_fire` in 1: I-cache request handshake completed this cycle.
- `icache_rsp_fire` in 1: I-cache response handshake completed this cycle.
- `dcache_req_fire` in NUM_REQS: per-lane D-cache request handshake.
- `dcache_req_rw` in NUM_REQS: per-lane direction, 1 = store, 0 = load.
- `dcache_rsp_fire` in NUM_REQS: per-lane load response handshake. Stores return no response.
- `ifetches`, `loads`, `stores` out PERF_CTR_BITS: request counts.
- `ifetch_latency`, `load_latency` out PERF_CTR_BITS: accumulated outstanding-cycles.
- `pending_ifetch`, `pending_loads` out PEND_BITS: current outstanding requests.
- `pend_err` out 1: sticky flag, set on pending overflow or underflow.

## Operation
- Per-cycle event counts:
  - `n_ld = popcount(dcache_req_fire & ~dcache_req_rw)`
  - `n_st = popcount(dcache_req_fire & dcache_req_rw)`
  - `n_lrsp = popcount(dcache_rsp_fire)`
- Pending counters update every cycle, independent of `perf_enable` and `perf_clear`:
  - `pending_ifetch += icache_req_fire - icache_rsp_fire`
  - `pending_loads += n_ld - n_lrsp`
- A simultaneous request and response on the same port leaves the pending counter unchanged.
- Pending counters saturate at 0 and at 2^PEND_BITS-1. Any clamped update sets `pend_err`.
- When `perf_enable`=1 and `perf_clear`=0:
  - `ifetches += icache_req_fire`, `loads += n_ld`, `stores += n_st`.
  - `ifetch_latency += pending_ifetch` and `load_latency += pending_loads`, using the registered values before this cycle's update.
- A request issued at cycle t and answered at cycle t+L therefore contributes exactly L to its latency counter.
- Event and latency counters wrap modulo 2^PERF_CTR_BITS. Wrap does not set `pend_err`.
- `perf_clear`=1 forces all event/latency counters and `pend_err` to 0 next cycle. This holds regardless of `perf_enable`, and events in that cycle are dropped. Pending counters are not cleared.
- `perf_enable`=0: event and latency counters hold. Pending tracking continues.

## Timing
- All outputs are registered. An input event is visible on the outputs 1 cycle later.
- Reset (`reset_n`=0, asynchronous): every output is 0 immediately and stays 0 until the first rising edge after deassertion.
- Reset asserted mid-operation discards all outstanding state. Responses arriving after reset for requests issued before it underflow the pending counters: those counters clamp at 0 and `pend_err` sets. This is the required behaviour.
- `pend_err` stays at 1 until `perf_clear` or reset. If a clamp and `perf_clear` occur in the same cycle, `perf_clear` wins.
- No handshakes are owned by this block. It observes fires only and never backpressures.

## Structure
- `PERF_CTR_BITS` comes from the shared `VX_define.vh` defines. `NUM_REQS` defaults to the LSU lane count define.
- Popcounts use the existing shared `VX_popcount`.
- One sub-module: `vx_perf_pending_ctr`. It is parameterized by increment/decrement widths, holds a saturating up/down counter with a clamp flag, and is instantiated twice (ifetch, loads).
- Top level holds five wrap-around accumulators, the enable/clear muxing, and the sticky `pend_err`.

## Test plan
- I-cache request at cycle 10, response at cycle 14, `perf_enable`=1 → `ifetches`=1, `ifetch_latency`=4, `pending_ifetch` back to 0 at cycle 15.
- `dcache_req_fire`=4'b1111 with `dcache_req_rw`=4'b0101 for one cycle, responses on lanes 1 and 3 three cycles later → `loads`=2, `stores`=2, `load_latency`=6, `pending_loads` ends at 0.
- `perf_enable`=0 during 5 outstanding-load cycles → `load_latency` unchanged; `pending_loads` still tracks; after re-enable, accumulation resumes from the held value.
- `perf_clear` pulsed while `pending_ifetch`=2 and `icache_req_fire`=1 → `ifetches`=0 next cycle, `pending_ifetch`=3, `pend_err`=0.
- `icache_rsp_fire` with `pending_ifetch`=0 → pending stays 0 and `pend_err`=1 until the next `perf_clear`. Separately, PEND_BITS=2 with 4 back-to-back requests → pending saturates at 3 and `pend_err`=1.
- `reset_n` dropped asynchronously mid-burst (between edges) → all outputs read 0 before the next edge. Preload a counter to 2^PERF_CTR_BITS-1 (via a short-width build) and add 1 → wraps to 0.
